// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer and a one-cycle response strobe.
// Latency: command accepted in IDLE, SETUP next cycle, response strobe the cycle after pready is sampled in ACCESS.
// Backpressure: cmd_ready drops while a transfer is in flight; rsp_valid cannot be stalled. Option: APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be at least 1");
  end

  state_t            state_q, state_d;
  logic              psel_d, penable_d, pwrite_d, cmd_ready_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              expire;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wd_q, wd_d;

  // pready in the expiry cycle takes priority, so expiry requires pready low
  assign expire = (state_q == ACCESS) && !pready && (wd_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_q == SETUP) begin
      wd_d = '0;
    end else if (state_q == ACCESS && !pready) begin
      wd_d = wd_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    cmd_ready_d   = cmd_ready;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = rsp_err;
    rsp_rdata_d   = rsp_rdata;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pwrite_d    = cmd_write;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready || expire) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pready ? pslverr : 1'b1;
          rsp_rdata_d   = (pready && !pwrite) ? prdata : '0;
          rsp_timeout_d = !pready;
          state_d       = IDLE;
        end
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        cmd_ready_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_err     <= rsp_err_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: table-driven register traffic plus queued, reset-abort and watchdog sequences.
module tb_apb_master;
  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  int n_pass = 0;
  int n_total = 0;
  int slave_mode = 0;
  int acc_cnt;
  logic [31:0] regs [4];

  always #5 pclk = ~pclk;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  // Register slave with registered pready: 0 = one wait cycle, 1 = never ready, 2 = ready on ACCESS cycle TO
  always @(posedge pclk) begin
    if (preset) begin
      pready  <= 1'b0;
      acc_cnt <= 0;
    end else begin
      acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
      case (slave_mode)
        0:       pready <= psel && penable && !pready;
        1:       pready <= 1'b0;
        default: pready <= psel && penable && (acc_cnt == TO - 2);
      endcase
      if (psel && penable && pready && pwrite && paddr < 32'h10) regs[paddr[3:2]] <= pwdata;
    end
  end
  assign pslverr = psel && penable && (paddr >= 32'h10);
  assign prdata  = (paddr < 32'h10) ? regs[paddr[3:2]] : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issue one command starting at a negedge with cmd_ready high; returns when rsp_valid is seen.
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic to,
                        output int nsel, output int nen, output logic pw, output logic [31:0] pd,
                        output bit aok, output bit ok);
    bit take;
    rd = '0; er = 1'b0; to = 1'b0; nsel = 0; nen = 0; pw = 1'b0; pd = '0; aok = 1'b1; ok = 1'b0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      take = cmd_valid && cmd_ready;
      @(negedge pclk);
      if (take) cmd_valid = 1'b0;
      if (psel) begin
        nsel++;
        pw = pwrite;
        pd = pwdata;
        if (paddr !== a) aok = 1'b0;
      end
      if (penable) nen++;
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; to = rsp_timeout; ok = 1'b1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tab [10];
  logic [31:0] qa [4];
  logic [31:0] qd [4];

  initial begin
    logic [31:0] rd, pd;
    logic        er, to, pw;
    int          nsel, nen, idx, nresp, nrise, gap;
    bit          aok, ok, take, prev_psel;
    int          bad_addr;

    tab[0] = '{1'b1, 32'h00, 32'h0000_1234, 32'h0, 1'b0};
    tab[1] = '{1'b1, 32'h04, 32'h2024_0115, 32'h0, 1'b0};
    tab[2] = '{1'b1, 32'h08, 32'h4142_4344, 32'h0, 1'b0};
    tab[3] = '{1'b1, 32'h0C, 32'h4546_4748, 32'h0, 1'b0};
    tab[4] = '{1'b0, 32'h00, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0};
    tab[5] = '{1'b0, 32'h04, 32'h0, 32'h2024_0115, 1'b0};
    tab[6] = '{1'b0, 32'h08, 32'h0, 32'h4142_4344, 1'b0};
    tab[7] = '{1'b0, 32'h0C, 32'h0, 32'h4546_4748, 1'b0};
    tab[8] = '{1'b0, 32'h10, 32'h0, 32'h0, 1'b1};
    tab[9] = '{1'b0, 32'h00, 32'h0, 32'h0000_1234, 1'b0};
    qa = '{32'h0C, 32'h08, 32'h04, 32'h00};
    qd = '{32'h4546_4748, 32'h4142_4344, 32'h2024_0115, 32'h0000_1234};

    // Reset values
    repeat (3) @(negedge pclk);
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 0);
    check("rst_pwrite", 32'(pwrite), 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    preset = 1'b0;
    @(negedge pclk);
    check("idle_cmd_ready", 32'(cmd_ready), 1);

    // Table: writes, read-back, unmapped error, recovery
    for (int i = 0; i < 10; i++) begin
      do_cmd(tab[i].w, tab[i].a, tab[i].d, rd, er, to, nsel, nen, pw, pd, aok, ok);
      check($sformatf("v%0d_done", i), 32'(ok), 1);
      check($sformatf("v%0d_rdata", i), rd, tab[i].exp_rd);
      check($sformatf("v%0d_err", i), 32'(er), 32'(tab[i].exp_err));
      check($sformatf("v%0d_timeout", i), 32'(to), 0);
      check($sformatf("v%0d_psel_cycles", i), 32'(nsel), 3);
      check($sformatf("v%0d_penable_cycles", i), 32'(nen), 2);
      check($sformatf("v%0d_pwrite", i), 32'(pw), 32'(tab[i].w));
      check($sformatf("v%0d_pwdata", i), pd, tab[i].w ? tab[i].d : 32'h0);
      check($sformatf("v%0d_paddr_stable", i), 32'(aok), 1);
      @(negedge pclk);
      check($sformatf("v%0d_strobe_1cyc", i), 32'(rsp_valid), 0);
      check($sformatf("v%0d_rdata_hold", i), rsp_rdata, tab[i].exp_rd);
    end

    // Four queued reads with cmd_valid held high
    idx = 0; nresp = 0; nrise = 0; gap = 0; prev_psel = 1'b0; bad_addr = 0;
    cmd_write = 1'b0; cmd_addr = qa[0]; cmd_valid = 1'b1;
    for (int c = 0; c < 200 && nresp < 4; c++) begin
      take = cmd_valid && cmd_ready;
      @(negedge pclk);
      if (take) begin
        idx++;
        if (idx < 4) cmd_addr = qa[idx];
        else cmd_valid = 1'b0;
      end
      if (psel && !prev_psel) begin
        if (nrise > 0) check($sformatf("q_gap%0d", nrise), 32'(gap), 1);
        nrise++;
        gap = 0;
      end
      if (!psel) gap++;
      if (psel && nrise > 0 && nrise <= 4 && paddr !== qa[nrise-1]) bad_addr++;
      if (rsp_valid) begin
        check($sformatf("q_rdata%0d", nresp), rsp_rdata, qd[nresp]);
        nresp++;
      end
      prev_psel = psel;
    end
    cmd_valid = 1'b0;
    check("q_responses", 32'(nresp), 4);
    check("q_transfers", 32'(nrise), 4);
    check("q_paddr_stable", 32'(bad_addr), 0);

    // Reset during ACCESS of a read
    cmd_write = 1'b0; cmd_addr = 32'h04; cmd_valid = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
    check("ra_setup", 32'({psel, penable}), 32'b10);
    @(negedge pclk);
    check("ra_access", 32'({psel, penable}), 32'b11);
    preset = 1'b1;
    @(negedge pclk);
    check("ra_psel", 32'(psel), 0);
    check("ra_penable", 32'(penable), 0);
    check("ra_rsp_valid", 32'(rsp_valid), 0);
    check("ra_paddr", paddr, 0);
    @(negedge pclk);
    check("ra_rsp_valid2", 32'(rsp_valid), 0);
    preset = 1'b0;
    @(negedge pclk);
    check("ra_cmd_ready", 32'(cmd_ready), 1);
    check("ra_rsp_valid3", 32'(rsp_valid), 0);
    do_cmd(1'b0, 32'h00, 32'h0, rd, er, to, nsel, nen, pw, pd, aok, ok);
    check("ra_recover_done", 32'(ok), 1);
    check("ra_recover_rdata", rd, 32'h0000_1234);
    @(negedge pclk);

`ifdef APB_MASTER_TIMEOUT_EN
    slave_mode = 1;
    do_cmd(1'b0, 32'h04, 32'h0, rd, er, to, nsel, nen, pw, pd, aok, ok);
    check("to_done", 32'(ok), 1);
    check("to_err", 32'(er), 1);
    check("to_timeout", 32'(to), 1);
    check("to_rdata", rd, 0);
    check("to_access_cycles", 32'(nen), TO);
    @(negedge pclk);
    slave_mode = 2;
    do_cmd(1'b0, 32'h04, 32'h0, rd, er, to, nsel, nen, pw, pd, aok, ok);
    check("tw_done", 32'(ok), 1);
    check("tw_err", 32'(er), 0);
    check("tw_timeout", 32'(to), 0);
    check("tw_rdata", rd, 32'h2024_0115);
    check("tw_access_cycles", 32'(nen), TO);
    @(negedge pclk);
    slave_mode = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
